// File: rtl/bus_fabric.sv
// Data-bus interconnect between the DLX data port and N memory-mapped slaves:
// base/mask address decode, posted writes, handshaked reads with timeout and error reporting.
module bus_fabric #(
   parameter int                         N_SLAVES  = 6,
   parameter int                         ADDR_W    = 32,
   parameter int                         DATA_W    = 32,
   parameter logic [N_SLAVES*ADDR_W-1:0] BASE      = '0,
   parameter logic [N_SLAVES*ADDR_W-1:0] MASK      = '1,
   parameter int                         TIMEOUT   = 15,
   parameter logic [DATA_W-1:0]          DEF_RDATA = 32'hDEAD_BEEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ADDR_W-1:0]          m_addr,
   input  logic [DATA_W-1:0]          m_wdata,
   input  logic                       m_we,
   input  logic                       m_re,
   output logic                       m_busy,
   output logic [DATA_W-1:0]          m_rdata,
   output logic                       m_rvalid,
   output logic                       m_err,
   output logic [7:0]                 err_count,
   output logic [N_SLAVES-1:0]        s_cs,
   output logic                       s_we,
   output logic [ADDR_W-1:0]          s_addr,
   output logic [DATA_W-1:0]          s_wdata,
   input  logic [N_SLAVES*DATA_W-1:0] s_rdata,
   input  logic [N_SLAVES-1:0]        s_rvalid
);

   localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t              state_q;
   logic [SEL_W-1:0]    sel_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                rvalid_q;
   logic                err_q;
   logic [7:0]          err_cnt_q;
   logic [7:0]          err_cnt_d;

   logic                hit;
   logic [SEL_W-1:0]    hit_idx;
   logic                sel_valid;
   logic [DATA_W-1:0]   sel_rdata;

   // Scanning from the top down lets the lowest matching index overwrite any higher one.
   // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((m_addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   assign sel_valid = s_rvalid[sel_q];
   assign sel_rdata = s_rdata[sel_q*DATA_W +: DATA_W];
   assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         sel_q     <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (m_we) begin
                  if (!hit) begin
                     err_q     <= 1'b1;
                     err_cnt_q <= err_cnt_d;
                  end
               end else if (m_re) begin
                  if (hit) begin
                     sel_q   <= hit_idx;
                     addr_q  <= m_addr;
                     cnt_q   <= '0;
                     state_q <= ST_WAIT;
                  end else begin
                     rvalid_q  <= 1'b1;
                     err_q     <= 1'b1;
                     rdata_q   <= DEF_RDATA;
                     err_cnt_q <= err_cnt_d;
                  end
               end
            end
            ST_WAIT: begin
               // A valid arriving on the last allowed cycle still completes normally.
               if (sel_valid) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= sel_rdata;
                  state_q  <= ST_IDLE;
               end else if (cnt_q == CNT_LAST) begin
                  rvalid_q  <= 1'b1;
                  err_q     <= 1'b1;
                  rdata_q   <= DEF_RDATA;
                  err_cnt_q <= err_cnt_d;
                  state_q   <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Writes select combinationally in IDLE; a pending read holds its latched slave and address.
   always_comb begin
      s_cs   = '0;
      s_we   = 1'b0;
      s_addr = m_addr;
      if (state_q == ST_WAIT) begin
         s_cs   = N_SLAVES'(1) << sel_q;
         s_addr = addr_q;
      end else if (m_we && hit) begin
         s_cs = N_SLAVES'(1) << hit_idx;
         s_we = 1'b1;
      end
   end

   assign s_wdata   = m_wdata;
   assign m_busy    = (state_q == ST_WAIT);
   assign m_rdata   = rdata_q;
   assign m_rvalid  = rvalid_q;
   assign m_err     = err_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Self-checking bench for bus_fabric: an address-range reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_fabric;

   localparam int N   = 6;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TO  = 4;
   localparam logic [31:0] DEF = 32'hDEAD_BEEF;

   // Slave 3 overlaps the low 256 bytes of slave 1 and must always lose to it.
   localparam logic [N*AW-1:0] BASE_P = {32'h0000_5000, 32'h0000_4000, 32'h0000_1000,
                                         32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
   localparam logic [N*AW-1:0] MASK_P = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00,
                                         32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

   logic          clk;
   logic          reset;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic          m_we;
   logic          m_re;
   logic          m_busy;
   logic [DW-1:0] m_rdata;
   logic          m_rvalid;
   logic          m_err;
   logic [7:0]    err_count;
   logic [N-1:0]  s_cs;
   logic          s_we;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic [N*DW-1:0] s_rdata;
   logic [N-1:0]  rv;
   logic [DW-1:0] rdata1;

   int n_cmp = 0;
   int n_bad = 0;

   assign s_rdata = {32'h5555_5555, 32'h4444_4444, 32'h3333_3333,
                     32'h0000_CAFE, rdata1, 32'h0000_0000};

   bus_fabric #(
      .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .BASE(BASE_P), .MASK(MASK_P),
      .TIMEOUT(TO), .DEF_RDATA(DEF)
   ) dut (
      .clk(clk), .reset(reset), .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
      .m_busy(m_busy), .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_err(m_err),
      .err_count(err_count), .s_cs(s_cs), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_rvalid(rv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Address map written as plain ranges; -1 means unmapped.
   function automatic int decode(input logic [31:0] a);
      if (a < 32'h1000) return 0;
      if (a < 32'h2000) return 1;
      if (a < 32'h3000) return 2;
      if (a >= 32'h4000 && a < 32'h5000) return 4;
      if (a >= 32'h5000 && a < 32'h6000) return 5;
      return -1;
   endfunction

   // Reference model: one outstanding read, how long it has waited, and the last response.
   bit          mdl_busy;
   int          mdl_sel;
   logic [31:0] mdl_addr;
   int          mdl_waited;
   bit          mdl_rvalid;
   bit          mdl_err;
   logic [31:0] mdl_rdata;
   int          mdl_errs;
   int          mdl_idx;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mdl_busy = 0; mdl_sel = 0; mdl_addr = '0; mdl_waited = 0;
         mdl_rvalid = 0; mdl_err = 0; mdl_rdata = '0; mdl_errs = 0;
      end else begin
         mdl_idx    = decode(m_addr);
         mdl_rvalid = 0;
         mdl_err    = 0;
         if (!mdl_busy) begin
            if (m_we) begin
               if (mdl_idx < 0) begin
                  mdl_err  = 1;
                  mdl_errs = (mdl_errs < 255) ? mdl_errs + 1 : 255;
               end
            end else if (m_re) begin
               if (mdl_idx < 0) begin
                  mdl_rvalid = 1; mdl_err = 1; mdl_rdata = DEF;
                  mdl_errs   = (mdl_errs < 255) ? mdl_errs + 1 : 255;
               end else begin
                  mdl_busy = 1; mdl_sel = mdl_idx; mdl_addr = m_addr; mdl_waited = 0;
               end
            end
         end else if (rv[mdl_sel]) begin
            mdl_rvalid = 1;
            mdl_rdata  = s_rdata[mdl_sel*32 +: 32];
            mdl_busy   = 0;
         end else begin
            mdl_waited++;
            if (mdl_waited >= TO) begin
               mdl_rvalid = 1; mdl_err = 1; mdl_rdata = DEF; mdl_busy = 0;
               mdl_errs   = (mdl_errs < 255) ? mdl_errs + 1 : 255;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      int          idx;
      logic [5:0]  exp_cs;
      idx = decode(m_addr);
      if (mdl_busy)                exp_cs = 6'b1 << mdl_sel;
      else if (m_we && idx >= 0)   exp_cs = 6'b1 << idx;
      else                         exp_cs = '0;
      check("mdl_busy",    m_busy,    mdl_busy);
      check("mdl_rvalid",  m_rvalid,  mdl_rvalid);
      check("mdl_err",     m_err,     mdl_err);
      check("mdl_rdata",   m_rdata,   mdl_rdata);
      check("mdl_errcnt",  err_count, mdl_errs);
      check("mdl_s_cs",    s_cs,      exp_cs);
      check("mdl_s_we",    s_we,      !mdl_busy && m_we && idx >= 0);
      check("mdl_s_addr",  s_addr,    mdl_busy ? mdl_addr : m_addr);
      check("mdl_s_wdata", s_wdata,   m_wdata);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int busy_n;

   initial begin
      reset = 1'b1; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_re = 1'b0;
      rv = 6'b000100; rdata1 = 32'h0000_1111;
      cyc(); cyc();
      check("rst_busy", m_busy, 0);
      check("rst_rdata", m_rdata, 0);
      check("rst_errcnt", err_count, 0);
      check("rst_cs", s_cs, 0);
      reset = 1'b0;

      // Posted write hit to slave 0, then write+read together behaves as a write.
      m_we = 1; m_addr = 32'h10; m_wdata = 32'h12; #1;
      check("wr_cs", s_cs, 6'b000001);
      check("wr_we", s_we, 1);
      check("wr_wdata", s_wdata, 32'h12);
      cyc(); m_we = 0;
      check("wr_noerr", m_err, 0);
      m_we = 1; m_re = 1; m_addr = 32'h2000; #1;
      check("wrrd_cs", s_cs, 6'b000100);
      cyc(); m_we = 0; m_re = 0;
      check("wrrd_nobusy", m_busy, 0);
      check("wrrd_norv", m_rvalid, 0);

      // Read slave 2 with valid tied high: response two cycles after issue.
      m_re = 1; m_addr = 32'h2008;
      cyc(); m_re = 0;
      check("rd2_busy", m_busy, 1);
      check("rd2_early", m_rvalid, 0);
      cyc();
      check("rd2_rvalid", m_rvalid, 1);
      check("rd2_rdata", m_rdata, 32'h0000_CAFE);
      check("rd2_noerr", m_err, 0);
      cyc();
      check("rd2_pulse", m_rvalid, 0);
      check("rd2_hold", m_rdata, 32'h0000_CAFE);

      // Unmapped read.
      m_re = 1; m_addr = 32'hFFFF_0000;
      cyc(); m_re = 0;
      check("um_rvalid", m_rvalid, 1);
      check("um_err", m_err, 1);
      check("um_rdata", m_rdata, DEF);
      check("um_errcnt", err_count, 1);
      check("um_busy", m_busy, 0);
      cyc();
      check("um_pulse", m_err, 0);

      // Timeout on slave 4, which never answers.
      m_re = 1; m_addr = 32'h4000;
      cyc(); m_re = 0;
      busy_n = 0;
      while (m_busy && busy_n < 20) begin
         busy_n++;
         cyc();
      end
      check("to_busy_cycles", busy_n, TO);
      check("to_rvalid", m_rvalid, 1);
      check("to_err", m_err, 1);
      check("to_rdata", m_rdata, DEF);
      check("to_errcnt", err_count, 2);

      // Overlapping slaves 1 and 3: slave 1 wins; a read issued during WAIT is dropped.
      m_we = 1; m_addr = 32'h1080; m_wdata = 32'h7; #1;
      check("ov_wr_cs", s_cs, 6'b000010);
      cyc(); m_we = 0;
      m_re = 1; m_addr = 32'h1000;
      cyc();
      m_re = 1; m_addr = 32'h2000; #1;
      check("ov_rd_cs", s_cs, 6'b000010);
      check("ov_rd_addr", s_addr, 32'h1000);
      cyc(); m_re = 0; rv[1] = 1'b1;
      check("ov_still_busy", m_busy, 1);
      cyc(); rv[1] = 1'b0;
      check("ov_rvalid", m_rvalid, 1);
      check("ov_rdata", m_rdata, 32'h0000_1111);
      check("ov_noerr", m_err, 0);
      cyc();
      check("ov_dropped_rv", m_rvalid, 0);
      check("ov_dropped_busy", m_busy, 0);

      // Error counter saturation.
      m_we = 1; m_addr = 32'hFFFF_0000;
      repeat (300) cyc();
      m_we = 0;
      cyc();
      check("sat_errcnt", err_count, 255);

      // Reset in the middle of a read clears everything immediately and silently.
      m_re = 1; m_addr = 32'h4000;
      cyc(); m_re = 0;
      check("rw_busy", m_busy, 1);
      #1 reset = 1'b1;
      #1;
      check("rw_busy0", m_busy, 0);
      check("rw_cs0", s_cs, 0);
      check("rw_we0", s_we, 0);
      check("rw_rv0", m_rvalid, 0);
      check("rw_err0", m_err, 0);
      check("rw_rdata0", m_rdata, 0);
      check("rw_errcnt0", err_count, 0);
      cyc(); cyc();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         check("rw_silent_rv", m_rvalid, 0);
         check("rw_silent_err", m_err, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
